// File: rtl/parity_link_defs.sv
// Shared definitions for the XOR-parity serial link (generator and receiver sides).
package parity_link_defs;

    // Receiver FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Line levels that delimit a frame
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Default and largest supported data word width
    localparam int DEFAULT_DATA_W = 4;
    localparam int MAX_DATA_W     = 16;

    // Parity check: XOR of data and parity bit must equal the selected sense (0 even, 1 odd).
    // Data is zero-extended by the caller, which leaves the XOR reduction unchanged.
    function automatic logic parity_mismatch(input logic [MAX_DATA_W-1:0] data,
                                             input logic                  par_bit,
                                             input logic                  odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is parameterised.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Recomputes XOR parity, flags parity/framing errors, and pulses valid for one cycle.
module parity_frame_rx
    import parity_link_defs::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

    rx_state_e          state_q, state_d;
    logic               rx_s;
    logic               rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_bit_q, par_bit_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;

    logic               start_edge;
    logic               bit_tick;
    logic               busy_c;
    logic               cnt_run;
    logic               cnt_wrap;
    logic               smp_data;
    logic               smp_par;
    logic               smp_stop;

    sync_2ff #(
        .RST_VAL(STOP_BIT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // A start needs a genuine falling edge, so a low stop bit cannot re-arm the receiver
    assign start_edge = (rx_s == START_BIT) && (rx_prev_q == STOP_BIT);
    assign bit_tick   = (cnt_q == FULL_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bit_tick && (bit_idx_q == LAST_IDX)) state_d = ST_PARITY;
            end
            ST_PARITY: begin
                if (bit_tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_tick) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag, counter control and per-state sample strobes
    always_comb begin
        busy_c   = 1'b0;
        cnt_run  = 1'b0;
        cnt_wrap = 1'b0;
        smp_data = 1'b0;
        smp_par  = 1'b0;
        smp_stop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                busy_c   = 1'b1;
                cnt_run  = 1'b1;
                cnt_wrap = (cnt_q == HALF_LAST);
            end
            ST_DATA: begin
                busy_c   = 1'b1;
                cnt_run  = 1'b1;
                cnt_wrap = bit_tick;
                smp_data = bit_tick;
            end
            ST_PARITY: begin
                busy_c   = 1'b1;
                cnt_run  = 1'b1;
                cnt_wrap = bit_tick;
                smp_par  = bit_tick;
            end
            ST_STOP: begin
                busy_c   = 1'b1;
                cnt_run  = 1'b1;
                cnt_wrap = bit_tick;
                smp_stop = bit_tick;
            end
            default: begin
            end
        endcase
    end

    // Datapath next-state: bit timer, shift register, parity capture and result registers
    always_comb begin
        rx_prev_d = rx_s;
        cnt_d     = (cnt_run && !cnt_wrap) ? cnt_q + CNT_W'(1) : '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        if (state_q == ST_START) begin
            bit_idx_d = '0;
        end

        if (smp_data) begin
            shift_d[bit_idx_q] = rx_s;
            bit_idx_d          = bit_idx_q + IDX_W'(1);
        end

        if (smp_par) begin
            par_bit_d = rx_s;
        end

        // Results update together on the stop-bit sample, whether or not errors are flagged
        if (smp_stop) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = parity_mismatch(MAX_DATA_W'(shift_q), par_bit_q, PARITY_ODD);
            ferr_d  = ~rx_s;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev_q <= STOP_BIT;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_c;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model. An even- and an odd-parity instance
// share the same serial line.
`timescale 1ns/1ps
module tb_parity_frame_rx;

    localparam int W   = 4;
    localparam int CPB = 4;
    // Two synchroniser edges, then the edge that first sees the low line, then mid-start
    // plus data, parity and stop bit periods.
    localparam int LAT = 3 + CPB / 2 + (W + 2) * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx;
    logic [W-1:0] data_e, data_o;
    logic         valid_e, valid_o;
    logic         perr_e, perr_o;
    logic         ferr_e, ferr_o;
    logic         busy_e, busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         perr;
        logic         ferr;
        int unsigned  cyc;
    } ev_t;

    ev_t q_e[$];
    ev_t q_o[$];

    parity_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_e), .valid(valid_e),
        .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e));

    parity_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_o), .valid(valid_o),
        .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which valid is high, with the values it presents
    always @(negedge clk) begin
        ev_t ev;
        if (valid_e) begin
            ev.data = data_e; ev.perr = perr_e; ev.ferr = ferr_e; ev.cyc = cyc;
            q_e.push_back(ev);
        end
        if (valid_o) begin
            ev.data = data_o; ev.perr = perr_o; ev.ferr = ferr_o; ev.cyc = cyc;
            q_o.push_back(ev);
        end
    end

    // Reference model: parity error when the count of ones in data+parity has the wrong sense
    function automatic logic model_perr(input logic [W-1:0] d, input logic p, input logic odd);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != int'(odd);
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({data_e, valid_e, perr_e, ferr_e, busy_e} !== '0) begin
            n_fail++;
            $display("FAIL reset_even: got %b want 0", {data_e, valid_e, perr_e, ferr_e, busy_e});
        end
        n_tests++;
        if ({data_o, valid_o, perr_o, ferr_o, busy_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_odd: got %b want 0", {data_o, valid_o, perr_o, ferr_o, busy_o});
        end
        rst = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_good_frame;
        int unsigned t0;
        q_e.delete(); q_o.delete();
        t0 = cyc;
        send_frame(4'hB, 1'b1, 1'b1);
        idle_bits(3);
        n_tests++;
        if (q_e.size() !== 1) begin
            n_fail++; $display("FAIL good_count: got %0d want 1", q_e.size());
        end
        if (q_e.size() > 0) begin
            n_tests++;
            if ({q_e[0].data, q_e[0].perr, q_e[0].ferr} !== {4'hB, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL good_result: got %h/%b/%b want b/0/0", q_e[0].data, q_e[0].perr, q_e[0].ferr);
            end
            n_tests++;
            if (q_e[0].cyc - t0 !== LAT) begin
                n_fail++; $display("FAIL good_latency: got %0d want %0d", q_e[0].cyc - t0, LAT);
            end
        end
        n_tests++;
        if ({data_e, busy_e} !== {4'hB, 1'b0}) begin
            n_fail++; $display("FAIL good_hold: got data %h busy %b want b/0", data_e, busy_e);
        end
    endtask

    task automatic test_parity_err;
        q_e.delete(); q_o.delete();
        send_frame(4'h6, 1'b1, 1'b1);
        idle_bits(3);
        n_tests++;
        if (q_e.size() !== 1 || q_o.size() !== 1) begin
            n_fail++; $display("FAIL perr_count: got %0d/%0d want 1/1", q_e.size(), q_o.size());
        end
        if (q_e.size() > 0) begin
            n_tests++;
            if ({q_e[0].data, q_e[0].perr, q_e[0].ferr} !== {4'h6, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL perr_even: got %h/%b/%b want 6/1/0", q_e[0].data, q_e[0].perr, q_e[0].ferr);
            end
        end
        if (q_o.size() > 0) begin
            n_tests++;
            if ({q_o[0].data, q_o[0].perr, q_o[0].ferr} !== {4'h6, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL perr_odd: got %h/%b/%b want 6/0/0", q_o[0].data, q_o[0].perr, q_o[0].ferr);
            end
        end
        n_tests++;
        if (perr_e !== 1'b1) begin
            n_fail++; $display("FAIL perr_held: got %b want 1", perr_e);
        end
    endtask

    task automatic test_glitch;
        logic saw_busy;
        q_e.delete(); q_o.delete();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        saw_busy = 1'b0;
        repeat (4 * CPB) begin
            @(negedge clk);
            if (busy_e) saw_busy = 1'b1;
        end
        n_tests++;
        if ({saw_busy, busy_e} !== 2'b10) begin
            n_fail++; $display("FAIL glitch_busy: got seen %b now %b want 1/0", saw_busy, busy_e);
        end
        n_tests++;
        if (q_e.size() !== 0) begin
            n_fail++; $display("FAIL glitch_valid: got %0d pulses want 0", q_e.size());
        end
        n_tests++;
        if ({data_e, perr_e, ferr_e} !== {4'h6, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL glitch_hold: got %h/%b/%b want 6/1/0", data_e, perr_e, ferr_e);
        end
    endtask

    task automatic test_frame_err;
        q_e.delete(); q_o.delete();
        send_frame(4'h3, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (10 * CPB) @(negedge clk);
        n_tests++;
        if (q_e.size() !== 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d want 1", q_e.size());
        end
        if (q_e.size() > 0) begin
            n_tests++;
            if ({q_e[0].data, q_e[0].perr, q_e[0].ferr} !== {4'h3, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL ferr_result: got %h/%b/%b want 3/0/1", q_e[0].data, q_e[0].perr, q_e[0].ferr);
            end
        end
        n_tests++;
        if (busy_e !== 1'b0) begin
            n_fail++; $display("FAIL ferr_no_rearm: got busy %b want 0", busy_e);
        end
        idle_bits(2);
        send_frame(4'h5, 1'b0, 1'b1);
        idle_bits(3);
        n_tests++;
        if (q_e.size() !== 2) begin
            n_fail++; $display("FAIL ferr_recover_count: got %0d want 2", q_e.size());
        end
        if (q_e.size() > 1) begin
            n_tests++;
            if ({q_e[1].data, q_e[1].perr, q_e[1].ferr} !== {4'h5, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL ferr_recover: got %h/%b/%b want 5/0/0", q_e[1].data, q_e[1].perr, q_e[1].ferr);
            end
        end
    endtask

    task automatic test_reset_mid;
        q_e.delete(); q_o.delete();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy_e !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy: got %b want 1", busy_e);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({data_e, valid_e, perr_e, ferr_e, busy_e} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got %b want 0", {data_e, valid_e, perr_e, ferr_e, busy_e});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_bits(3);
        n_tests++;
        if (q_e.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_no_valid: got %0d want 0", q_e.size());
        end
        send_frame(4'h9, 1'b0, 1'b1);
        idle_bits(3);
        n_tests++;
        if (q_e.size() !== 1) begin
            n_fail++; $display("FAIL rstmid_next_count: got %0d want 1", q_e.size());
        end
        if (q_e.size() > 0) begin
            n_tests++;
            if ({q_e[0].data, q_e[0].perr, q_e[0].ferr} !== {4'h9, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rstmid_next: got %h/%b/%b want 9/0/0", q_e[0].data, q_e[0].perr, q_e[0].ferr);
            end
        end
    endtask

    task automatic test_back_to_back;
        q_e.delete(); q_o.delete();
        send_frame(4'hF, 1'b0, 1'b1);
        send_frame(4'h1, 1'b1, 1'b1);
        idle_bits(3);
        n_tests++;
        if (q_e.size() !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 2", q_e.size());
        end
        if (q_e.size() > 1) begin
            n_tests++;
            if ({q_e[0].data, q_e[0].perr, q_e[0].ferr, q_e[1].data, q_e[1].perr, q_e[1].ferr}
                    !== {4'hF, 2'b00, 4'h1, 2'b00}) begin
                n_fail++;
                $display("FAIL b2b_result: got %h/%b/%b %h/%b/%b want f/0/0 1/0/0", q_e[0].data,
                         q_e[0].perr, q_e[0].ferr, q_e[1].data, q_e[1].perr, q_e[1].ferr);
            end
            n_tests++;
            if (q_e[1].cyc - q_e[0].cyc !== 7 * CPB) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", q_e[1].cyc - q_e[0].cyc, 7 * CPB);
            end
        end
    endtask

    task automatic test_random;
        ev_t exp_q[$];
        ev_t ev;
        logic [W-1:0] d;
        logic p, s;
        int gap;
        q_e.delete(); q_o.delete();
        for (int i = 0; i < 12; i++) begin
            d   = W'($urandom_range(0, (1 << W) - 1));
            p   = 1'($urandom_range(0, 1));
            s   = ($urandom_range(0, 3) != 0);
            gap = s ? $urandom_range(0, 2) : $urandom_range(1, 2);
            ev.data = d; ev.perr = p; ev.ferr = ~s; ev.cyc = 0;
            exp_q.push_back(ev);
            send_frame(d, p, s);
            idle_bits(gap);
        end
        idle_bits(3);
        n_tests++;
        if (q_e.size() !== exp_q.size() || q_o.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d/%0d want %0d", q_e.size(), q_o.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q_e.size()) begin
                n_tests++;
                if ({q_e[i].data, q_e[i].perr, q_e[i].ferr} !==
                    {exp_q[i].data, model_perr(exp_q[i].data, exp_q[i].perr, 1'b0), exp_q[i].ferr}) begin
                    n_fail++;
                    $display("FAIL rand_even[%0d]: got %h/%b/%b want %h/%b/%b", i, q_e[i].data,
                             q_e[i].perr, q_e[i].ferr, exp_q[i].data,
                             model_perr(exp_q[i].data, exp_q[i].perr, 1'b0), exp_q[i].ferr);
                end
            end
            if (i < q_o.size()) begin
                n_tests++;
                if (q_o[i].perr !== model_perr(exp_q[i].data, exp_q[i].perr, 1'b1)) begin
                    n_fail++;
                    $display("FAIL rand_odd[%0d]: got perr %b want %b", i, q_o[i].perr,
                             model_perr(exp_q[i].data, exp_q[i].perr, 1'b1));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_parity_err();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
